// File: rtl/keystream_gen.sv
// keystream_gen: expands a 64-bit key into chained xorshift64 keystream words
// and serves them one byte per request, least-significant byte first.

package types_pkg;
   typedef enum logic [2:0] {
      GROUND,
      FIRST_QUERRY,
      READY,
      QUERRIED,
      PULSE_OUT,
      EXHAUSTED
   } hash_generator_state_t;
endpackage

module keystream_gen #(
   parameter int          ROUNDS   = 4,
   parameter logic [63:0] ZERO_FIX = 64'h9E37_79B9_7F4A_7C15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_load,
   input  logic [63:0] key,
   input  logic        req,
   output logic [7:0]  ks_byte,
   output logic        ks_valid,
   output logic        busy
);
   import types_pkg::*;

   // Round counter value on which the final round of a word is taken.
   localparam logic [3:0] LP_LAST_RND = 4'(ROUNDS - 1);

   // One xorshift64 round; all shifts are logical and truncated to 64 bits.
   function automatic logic [63:0] xs(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

   hash_generator_state_t r_state;
   hash_generator_state_t w_state_next;

   logic [63:0] r_seed;
   logic [63:0] r_work;
   logic [63:0] r_buffer;
   logic [3:0]  r_marker;
   logic [3:0]  r_rnd;
   logic [7:0]  r_ks_byte;

   logic [63:0] w_xs_work;
   logic [5:0]  w_byte_sel;
   logic        w_ks_valid;
   logic        w_busy;

   assign w_xs_work  = xs(r_work);
   // marker is 1..7 whenever QUERRIED uses this, so the low 3 bits suffice.
   assign w_byte_sel = {r_marker[2:0], 3'b000};

   assign ks_byte  = r_ks_byte;
   assign ks_valid = w_ks_valid;
   assign busy     = w_busy;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= GROUND;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and state-decoded outputs; key_load overrides any transition.
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_ks_valid   = 1'b0;
      case (r_state)
         GROUND, EXHAUSTED: begin
            if (req) begin
               w_state_next = FIRST_QUERRY;
            end
         end
         FIRST_QUERRY: begin
            w_busy = 1'b1;
            if (r_rnd == LP_LAST_RND) begin
               w_state_next = PULSE_OUT;
            end
         end
         READY: begin
            if (req) begin
               w_state_next = QUERRIED;
            end
         end
         QUERRIED: begin
            w_busy       = 1'b1;
            w_state_next = PULSE_OUT;
         end
         PULSE_OUT: begin
            w_busy       = 1'b1;
            w_ks_valid   = 1'b1;
            w_state_next = (r_marker == 4'd8) ? EXHAUSTED : READY;
         end
         default: begin
            w_state_next = GROUND;
         end
      endcase
      if (key_load) begin
         w_state_next = GROUND;
      end
   end

   // Datapath: key loading, word generation with seed chaining, byte serving.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seed    <= 64'd0;
         r_work    <= 64'd0;
         r_buffer  <= 64'd0;
         r_marker  <= 4'd0;
         r_rnd     <= 4'd0;
         r_ks_byte <= 8'd0;
      end else if (key_load) begin
         // An all-zero seed would lock xorshift at zero forever.
         r_seed   <= (key == 64'd0) ? ZERO_FIX : key;
         r_buffer <= 64'd0;
         r_marker <= 4'd0;
         r_rnd    <= 4'd0;
      end else begin
         case (r_state)
            GROUND, EXHAUSTED: begin
               if (req) begin
                  r_work <= r_seed;
                  r_rnd  <= 4'd0;
               end
            end
            FIRST_QUERRY: begin
               if (r_rnd == LP_LAST_RND) begin
                  // The finished word also becomes the seed of the next word.
                  r_buffer  <= w_xs_work;
                  r_seed    <= w_xs_work;
                  r_ks_byte <= w_xs_work[7:0];
                  r_marker  <= 4'd1;
               end else begin
                  r_work <= w_xs_work;
                  r_rnd  <= r_rnd + 4'd1;
               end
            end
            QUERRIED: begin
               r_ks_byte <= r_buffer[w_byte_sel +: 8];
               r_marker  <= r_marker + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keystream_gen.sv
// tb_keystream_gen: table-driven requests plus hand-written corner sequences
// against two instances (ROUNDS=1 and ROUNDS=4); a scoreboard queue holds the
// expected byte and pulse cycle of every accepted request.

module tb_keystream_gen;
   localparam logic [63:0] ZF = 64'h9E37_79B9_7F4A_7C15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0, req1, kl0, kl1;
   logic [63:0] key0, key1;
   logic [7:0]  byte0, byte1;
   logic        val0, val1, busy0, busy1;

   keystream_gen #(.ROUNDS(1), .ZERO_FIX(ZF)) u_r1 (
      .clk(clk), .rst(rst), .key_load(kl0), .key(key0), .req(req0),
      .ks_byte(byte0), .ks_valid(val0), .busy(busy0)
   );

   keystream_gen #(.ROUNDS(4), .ZERO_FIX(ZF)) u_r4 (
      .clk(clk), .rst(rst), .key_load(kl1), .key(key1), .req(req1),
      .ks_byte(byte1), .ks_valid(val1), .busy(busy1)
   );

   typedef struct {
      int         sel;
      logic [7:0] b;
      int         cyc;
   } exp_t;

   typedef struct {
      int          sel;
      bit          load;
      logic [63:0] key;
      bit          use_model;
      logic [7:0]  exp_byte;
      int          lat;
   } vec_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          pops     = 0;
   int          run_len[2];
   int          last_run[2];
   logic [7:0]  last_exp[2];

   logic [63:0] m_seed[2];
   logic [63:0] m_word[2];
   int          m_idx[2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rounds_of(int s);
      return (s == 0) ? 1 : 4;
   endfunction

   function automatic logic [63:0] xs_ref(logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

   task automatic model_load(int s, logic [63:0] k);
      m_seed[s] = (k == 64'd0) ? ZF : k;
      m_idx[s]  = 8;
   endtask

   task automatic model_next(int s, output logic [7:0] b);
      logic [63:0] w;
      if (m_idx[s] == 8) begin
         w = m_seed[s];
         for (int r = 0; r < rounds_of(s); r++) w = xs_ref(w);
         m_word[s] = w;
         m_seed[s] = w;
         m_idx[s]  = 0;
      end
      b = m_word[s][8*m_idx[s] +: 8];
      m_idx[s]++;
   endtask

   // Scoreboard monitor: every pulse must match the head of the queue in
   // instance, byte and cycle; also measures the length of each busy run.
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         logic       v;
         logic       bz;
         logic [7:0] b;
         exp_t       e;
         v  = (s == 0) ? val0 : val1;
         bz = (s == 0) ? busy0 : busy1;
         b  = (s == 0) ? byte0 : byte1;
         if (v) begin
            checks++;
            if (sb_q.size() == 0 || sb_q[0].sel != s) begin
               failures++;
               $display("FAIL unexpected_pulse dut%0d actual byte=%02h cyc=%0d required=no pulse", s, b, cyc);
            end else begin
               e = sb_q.pop_front();
               pops++;
               last_exp[s] = e.b;
               if (b !== e.b) begin
                  failures++;
                  $display("FAIL pulse_byte dut%0d actual=%02h required=%02h", s, b, e.b);
               end
               checks++;
               if (cyc != e.cyc) begin
                  failures++;
                  $display("FAIL pulse_cycle dut%0d actual=%0d required=%0d", s, cyc, e.cyc);
               end
               $display("txn dut%0d byte=%02h exp=%02h cyc=%0d exp_cyc=%0d", s, b, e.b, cyc, e.cyc);
            end
         end
         if (bz) begin
            run_len[s]++;
         end else begin
            if (run_len[s] > 0) last_run[s] = run_len[s];
            run_len[s] = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(int s, logic r, logic kl, logic [63:0] k);
      if (s == 0) begin
         req0 = r; kl0 = kl; key0 = k;
      end else begin
         req1 = r; kl1 = kl; key1 = k;
      end
   endtask

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_load(int s, logic [63:0] k);
      drive(s, 1'b0, 1'b1, k);
      tick();
      drive(s, 1'b0, 1'b0, k);
      model_load(s, k);
   endtask

   // One request from an idle state; waits for its pulse, then checks busy length.
   task automatic do_req(int s, bit use_model, logic [7:0] hand, int lat, string name);
      logic [7:0] eb;
      exp_t       e;
      int         waited;
      model_next(s, eb);
      e.sel = s;
      e.b   = use_model ? eb : hand;
      e.cyc = cyc + lat;
      sb_q.push_back(e);
      drive(s, 1'b1, 1'b0, 64'd0);
      tick();
      drive(s, 1'b0, 1'b0, 64'd0);
      waited = 0;
      while (sb_q.size() != 0 && waited < 40) begin
         tick();
         waited++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no pulse required=pulse within 40 cycles", name);
         sb_q.delete();
      end
      tick();
      check({name, "_busy_len"}, 64'(last_run[s]), 64'(lat));
   endtask

   function automatic vec_t mk(int sel, bit load, logic [63:0] key, bit um, logic [7:0] b, int lat);
      vec_t v;
      v.sel = sel; v.load = load; v.key = key; v.use_model = um; v.exp_byte = b; v.lat = lat;
      return v;
   endfunction

   initial begin
      vec_t        vt[18];
      logic [7:0]  hb[8];
      exp_t        e;
      logic [7:0]  b;
      int          t;
      int          p0;
      int          waited;

      hb = '{8'h41, 8'h20, 8'h82, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
      // ROUNDS=1, key=1: xs(1)=64'h4082_2041, then a refill from the chained seed.
      for (int i = 0; i < 8; i++) vt[i] = mk(0, (i == 0), 64'd1, 1'b0, hb[i], 2);
      vt[8]  = mk(0, 1'b0, 64'd0, 1'b1, 8'h00, 2);
      vt[9]  = mk(0, 1'b0, 64'd0, 1'b1, 8'h00, 2);
      // ROUNDS=4: key=0 and ZERO_FIX loaded directly must give the same stream.
      vt[10] = mk(1, 1'b1, 64'd0, 1'b1, 8'h00, 5);
      for (int i = 11; i < 14; i++) vt[i] = mk(1, 1'b0, 64'd0, 1'b1, 8'h00, 2);
      vt[14] = mk(1, 1'b1, ZF, 1'b1, 8'h00, 5);
      for (int i = 15; i < 18; i++) vt[i] = mk(1, 1'b0, 64'd0, 1'b1, 8'h00, 2);

      for (int s = 0; s < 2; s++) begin
         run_len[s] = 0; last_run[s] = 0; last_exp[s] = 8'h00;
         m_seed[s] = 64'd0; m_word[s] = 64'd0; m_idx[s] = 8;
      end

      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 64'd0);
      drive(1, 1'b0, 1'b0, 64'd0);
      repeat (3) tick();
      rst = 1'b0;

      // Reset state held while idle.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_byte0", 64'(byte0), 64'd0);
         check("rst_valid0", 64'(val0), 64'd0);
         check("rst_busy0", 64'(busy0), 64'd0);
         check("rst_byte1", 64'(byte1), 64'd0);
         check("rst_valid1", 64'(val1), 64'd0);
         check("rst_busy1", 64'(busy1), 64'd0);
      end

      // Table-driven single requests.
      for (int i = 0; i < 18; i++) begin
         if (vt[i].load) do_load(vt[i].sel, vt[i].key);
         do_req(vt[i].sel, vt[i].use_model, vt[i].exp_byte, vt[i].lat, $sformatf("vec%0d", i));
      end

      // req held high: one pulse per accepted request, busy cycles ignored.
      do_load(1, 64'h0123_4567_89AB_CDEF);
      t  = cyc + 5;
      p0 = pops;
      for (int k = 0; k < 10; k++) begin
         model_next(1, b);
         e.sel = 1; e.b = b; e.cyc = t;
         sb_q.push_back(e);
         t += (k == 7) ? 6 : 3;
      end
      drive(1, 1'b1, 1'b0, 64'd0);
      waited = 0;
      while (pops - p0 < 10 && waited < 100) begin
         tick();
         waited++;
      end
      drive(1, 1'b0, 1'b0, 64'd0);
      if (pops - p0 < 10) begin
         checks++;
         failures++;
         $display("FAIL held_req_timeout actual=%0d pulses required=10", pops - p0);
         sb_q.delete();
      end
      repeat (10) tick();
      check("held_req_idle_busy", 64'(busy1), 64'd0);

      // key_load with req during FIRST_QUERRY aborts generation.
      do_load(1, 64'hDEAD_BEEF_0BAD_F00D);
      drive(1, 1'b1, 1'b0, 64'd0);
      tick();
      drive(1, 1'b0, 1'b0, 64'd0);
      tick();
      drive(1, 1'b1, 1'b1, 64'h1357_9BDF_2468_ACE0);
      tick();
      drive(1, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0);
      check("abort_busy", 64'(busy1), 64'd0);
      check("abort_valid", 64'(val1), 64'd0);
      check("abort_byte_kept", 64'(byte1), 64'(last_exp[1]));
      model_load(1, 64'h1357_9BDF_2468_ACE0);
      repeat (8) tick();
      do_req(1, 1'b1, 8'h00, 5, "after_abort");

      // Reset during FIRST_QUERRY clears everything, no pulse follows.
      do_load(1, 64'hCAFE_F00D_1234_5678);
      drive(1, 1'b1, 1'b0, 64'd0);
      tick();
      drive(1, 1'b0, 1'b0, 64'd0);
      tick();
      rst = 1'b1;
      drive(1, 1'b1, 1'b0, 64'd0);
      tick();
      rst = 1'b0;
      drive(1, 1'b0, 1'b0, 64'd0);
      check("rstabort_byte", 64'(byte1), 64'd0);
      check("rstabort_valid", 64'(val1), 64'd0);
      check("rstabort_busy", 64'(busy1), 64'd0);
      check("rstabort_byte_r1", 64'(byte0), 64'd0);
      repeat (8) tick();
      check("rstabort_idle_busy", 64'(busy1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
